mult_accum_stage: RTL and testbench

- Sequential accumulator directly downstream of the 4x4 array multiplier.
- Consumes the multiplier's 8-bit products one per transfer through a valid/ready handshake and sums a group of products (dot-product style).
- Presents the group sum, the term count and an overflow flag on a valid/ready output port.
- Group ends on an explicit last marker or on reaching MAX_TERMS.

---
 rtl/mult_accum_stage.sv | 87 ++++++++
 tb/tb_mult_accum_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_accum_stage.sv
// rtl/mult_accum_stage.sv - accumulates multiplier products into per-group sums over valid/ready
module mult_accum_stage #(
    parameter int PW        = 8,
    parameter int AW        = 12,
    parameter int MAX_TERMS = 16,
    parameter int SATURATE  = 1,
    parameter int CW        = $clog2(MAX_TERMS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_p,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_sum,
    output logic [CW-1:0] out_count,
    output logic          out_ovf
);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;
    logic          ovf;

    logic          in_xfer;
    logic          grp_end;
    logic [AW:0]   nxt;
    logic [AW-1:0] acc_new;
    logic [CW-1:0] cnt_new;
    logic          ovf_new;

    // acc/cnt/ovf are already cleared while in HOLD, so a beat taken there
    // naturally becomes the first term of the next group.
    always_comb begin
        in_ready  = (state == ACC) || out_ready;
        out_valid = (state == HOLD);
        in_xfer   = in_valid && in_ready;
        nxt       = {1'b0, acc} + {{(AW + 1 - PW){1'b0}}, in_p};
        acc_new   = ((SATURATE != 0) && nxt[AW]) ? {AW{1'b1}} : nxt[AW-1:0];
        ovf_new   = ovf | nxt[AW];
        cnt_new   = cnt + CW'(1);
        grp_end   = in_last || (cnt_new == CW'(MAX_TERMS));
        state_nxt = state;
        if (in_xfer) begin
            state_nxt = grp_end ? HOLD : ACC;
        end else if ((state == HOLD) && out_ready) begin
            state_nxt = ACC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACC;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (in_xfer) begin
                if (grp_end) begin
                    out_sum   <= acc_new;
                    out_count <= cnt_new;
                    out_ovf   <= ovf_new;
                    acc       <= '0;
                    cnt       <= '0;
                    ovf       <= 1'b0;
                end else begin
                    acc <= acc_new;
                    cnt <= cnt_new;
                    ovf <= ovf_new;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_accum_stage.sv
// tb/tb_mult_accum_stage.sv - self-checking bench for mult_accum_stage
module tb_mult_accum_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_p;
    logic        in_last;
    logic        out_ready;

    logic        in_ready, out_valid, out_ovf;
    logic [11:0] out_sum;
    logic [4:0]  out_count;
    logic        in_ready_s, out_valid_s, out_ovf_s;
    logic [9:0]  out_sum_s;
    logic [4:0]  out_count_s;
    logic        in_ready_w, out_valid_w, out_ovf_w;
    logic [9:0]  out_sum_w;
    logic [4:0]  out_count_w;

    mult_accum_stage #(.PW(8), .AW(12), .MAX_TERMS(16), .SATURATE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_p(in_p),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf));

    mult_accum_stage #(.PW(8), .AW(10), .MAX_TERMS(16), .SATURATE(1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_p(in_p),
        .in_last(in_last), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_sum(out_sum_s), .out_count(out_count_s), .out_ovf(out_ovf_s));

    mult_accum_stage #(.PW(8), .AW(10), .MAX_TERMS(16), .SATURATE(0)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .in_p(in_p),
        .in_last(in_last), .out_valid(out_valid_w), .out_ready(out_ready),
        .out_sum(out_sum_w), .out_count(out_count_w), .out_ovf(out_ovf_w));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    typedef struct {
        int cnt;
        int s12, o12, s10s, o10s, s10w, o10w;
    } exp_t;

    // Sums of non-negative terms grow monotonically, so the group total alone
    // decides the saturated value, the wrapped value and the overflow flag.
    function automatic exp_t model(input int total, input int n);
        exp_t e;
        e.cnt  = n;
        e.s12  = (total > 4095) ? 4095 : total;
        e.o12  = (total > 4095) ? 1 : 0;
        e.s10s = (total > 1023) ? 1023 : total;
        e.o10s = (total > 1023) ? 1 : 0;
        e.s10w = total % 1024;
        e.o10w = (total >= 1024) ? 1 : 0;
        return e;
    endfunction

    int   grp[$];
    exp_t expq[$];
    int   n_groups = 0;

    always @(negedge clk) begin
        exp_t e;
        int   tot;
        if (rst) begin
            grp.delete();
            expq.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    e = expq.pop_front();
                    check("sb_count", out_count, e.cnt);
                    check("sb_sum12", out_sum, e.s12);
                    check("sb_ovf12", out_ovf, e.o12);
                    check("sb_sum10s", out_sum_s, e.s10s);
                    check("sb_ovf10s", out_ovf_s, e.o10s);
                    check("sb_sum10w", out_sum_w, e.s10w);
                    check("sb_ovf10w", out_ovf_w, e.o10w);
                end
            end
            if (in_valid && in_ready) begin
                grp.push_back(int'(in_p));
                if (in_last || grp.size() == 16) begin
                    tot = 0;
                    foreach (grp[i]) tot += grp[i];
                    expq.push_back(model(tot, grp.size()));
                    grp.delete();
                    n_groups++;
                end
            end
        end
    end

    task automatic send_beat(input int p, input bit last);
        int w;
        in_valid = 1'b1;
        in_p     = p[7:0];
        in_last  = last;
        w        = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            @(negedge clk);
            w++;
        end
        if (!in_ready) check("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    typedef struct {
        int n, v;
        bit last;
        int s12, o12, s10s, o10s, s10w, o10w;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{16, 225, 1'b0, 3600, 0, 1023, 1, 528, 1};
        tbl[1] = '{1, 225, 1'b1, 225, 0, 225, 0, 225, 0};
        tbl[2] = '{5, 225, 1'b1, 1125, 0, 1023, 1, 101, 1};
        tbl[3] = '{1, 0, 1'b1, 0, 0, 0, 0, 0, 0};
        tbl[4] = '{4, 255, 1'b1, 1020, 0, 1020, 0, 1020, 0};
        tbl[5] = '{5, 205, 1'b1, 1025, 0, 1023, 1, 1, 1};
        tbl[6] = '{16, 255, 1'b0, 4080, 0, 1023, 1, 1008, 1};

        rst = 1'b1; in_valid = 1'b0; in_p = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_count", out_count, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_in_ready_s", in_ready_s, 1);
        check("rst_in_ready_w", in_ready_w, 1);
        @(posedge clk); #1;
        rst = 1'b0;

        // basic group 3,5,7
        send_beat(3, 0);
        send_beat(5, 0);
        send_beat(7, 1);
        @(negedge clk);
        check("t1_valid", out_valid, 1);
        check("t1_sum", out_sum, 15);
        check("t1_count", out_count, 3);
        check("t1_ovf", out_ovf, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_back_valid", out_valid, 0);
        check("t1_back_ready", in_ready, 1);
        @(posedge clk); #1;

        for (int t = 0; t < 7; t++) begin
            for (int k = 0; k < tbl[t].n; k++) send_beat(tbl[t].v, tbl[t].last && (k == tbl[t].n - 1));
            @(negedge clk);
            check($sformatf("tbl%0d_valid", t), out_valid, 1);
            check($sformatf("tbl%0d_valid_s", t), out_valid_s, 1);
            check($sformatf("tbl%0d_valid_w", t), out_valid_w, 1);
            check($sformatf("tbl%0d_count", t), out_count, tbl[t].n);
            check($sformatf("tbl%0d_count_s", t), out_count_s, tbl[t].n);
            check($sformatf("tbl%0d_count_w", t), out_count_w, tbl[t].n);
            check($sformatf("tbl%0d_sum12", t), out_sum, tbl[t].s12);
            check($sformatf("tbl%0d_ovf12", t), out_ovf, tbl[t].o12);
            check($sformatf("tbl%0d_sum10s", t), out_sum_s, tbl[t].s10s);
            check($sformatf("tbl%0d_ovf10s", t), out_ovf_s, tbl[t].o10s);
            check($sformatf("tbl%0d_sum10w", t), out_sum_w, tbl[t].s10w);
            check($sformatf("tbl%0d_ovf10w", t), out_ovf_w, tbl[t].o10w);
            @(posedge clk); #1;
        end

        // backpressure, then a same-cycle single-beat group
        out_ready = 1'b0;
        send_beat(1, 0);
        send_beat(2, 1);
        in_valid = 1'b1; in_p = 8'd9; in_last = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_valid", out_valid, 1);
            check("bp_sum", out_sum, 3);
            check("bp_count", out_count, 2);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        check("b2b_valid", out_valid, 1);
        check("b2b_sum", out_sum, 9);
        check("b2b_count", out_count, 1);
        @(posedge clk); #1;

        // reset mid-group
        send_beat(10, 0);
        send_beat(20, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_valid", out_valid, 0);
        @(posedge clk); #1;
        send_beat(4, 1);
        @(negedge clk);
        check("abort_sum", out_sum, 4);
        check("abort_count", out_count, 1);
        @(posedge clk); #1;

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(3) != 0);
            in_p      = 8'($urandom_range(15) * $urandom_range(15));
            in_last   = ($urandom_range(5) == 0);
            out_ready = ($urandom_range(2) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("drain_pending", expq.size(), 0);
        check("groups_seen", (n_groups > 20) ? 1 : 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
